// File: rtl/apb_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB register completer: bus widths, the
// response FSM encoding, fixed response values and a byte-lane merge helper.
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_AW = 20;
  localparam int APB_DW = 16;

  // Read data returned with an error response.
  localparam logic [APB_DW-1:0] APB_ERR_DATA = 16'h0000;
  // Marker the master substitutes on an errored transfer ("ER").
  localparam logic [APB_DW-1:0] APB_DEAD     = 16'h4552;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_state_e;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [APB_DW-1:0] strb_merge(
    input logic [APB_DW-1:0] old_val,
    input logic [APB_DW-1:0] new_val,
    input logic [1:0]        strb
  );
    logic [APB_DW-1:0] res;
    res = old_val;
    if (strb[0]) res[7:0]  = new_val[7:0];
    if (strb[1]) res[15:8] = new_val[15:8];
    return res;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// ---------------------------------------------------------------------------
// apb_addr_decode
// Combinational halfword address decoder for the register window.
//   paddr  in  : byte address
//   pwrite in  : 1 = write access
//   idx    out : register index (low bits of (paddr-BASE_ADDR)>>1)
//   is_rw  out : address hits a read/write register
//   is_ro  out : address hits a read-only register
//   err    out : misaligned, out of window, or write to a read-only register
// A write with no byte strobes is also an error but is flagged by the caller,
// which owns the strobes.
// ---------------------------------------------------------------------------
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR = 20'h00000,
  parameter int                NUM_RW    = 8,
  parameter int                NUM_RO    = 4,
  parameter int                IDX_W     = 4
) (
  input  logic [APB_AW-1:0] paddr,
  input  logic              pwrite,
  output logic [IDX_W-1:0]  idx,
  output logic              is_rw,
  output logic              is_ro,
  output logic              err
);

  localparam logic [APB_AW-2:0] RW_LIM  = (APB_AW-1)'(NUM_RW);
  localparam logic [APB_AW-2:0] TOT_LIM = (APB_AW-1)'(NUM_RW + NUM_RO);

  logic [APB_AW-1:0] off;
  logic [APB_AW-2:0] word_idx;
  logic              below_base;
  logic              aligned;
  logic              off_lsb_unused;

  always_comb begin
    off        = paddr - BASE_ADDR;
    word_idx   = off[APB_AW-1:1];
    // Alignment is judged on the raw address, not on the offset.
    off_lsb_unused = off[0];
    below_base = (paddr < BASE_ADDR);
    aligned    = ~paddr[0];
    is_rw      = ~below_base & aligned & (word_idx < RW_LIM);
    is_ro      = ~below_base & aligned & (word_idx >= RW_LIM) & (word_idx < TOT_LIM);
    err        = ~(is_rw | is_ro) | (pwrite & is_ro);
    idx        = word_idx[IDX_W-1:0];
  end

endmodule

// File: rtl/apb_reg_slave.sv
// ---------------------------------------------------------------------------
// apb_reg_slave
// APB completer exposing a 16-bit register file: NUM_RW read/write registers
// followed by NUM_RO read-only status registers, with WAIT_CYCLES wait
// states before each response.
//   clk, reset_n       : clock, asynchronous active-low reset
//   psel, penable      : APB select / enable
//   pwrite, pstrb      : direction, byte-lane strobes (bit1=[15:8], bit0=[7:0])
//   paddr, pwdata      : byte address, write data
//   pready, prdata,
//   pslverr            : registered response (pready/pslverr one cycle wide)
//   ro_in              : read-only register values, word k at [16k+15:16k]
//   rw_q               : read/write register contents, flattened
//   wr_pulse           : one-cycle strobe per RW register after a committed write
// ---------------------------------------------------------------------------
module apb_reg_slave
  import apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] BASE_ADDR   = 20'h00000,
  parameter int                NUM_RW      = 8,
  parameter int                NUM_RO      = 4,
  parameter int                WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [1:0]               pstrb,
  input  logic [APB_AW-1:0]        paddr,
  input  logic [APB_DW-1:0]        pwdata,
  output logic                     pready,
  output logic [APB_DW-1:0]        prdata,
  output logic                     pslverr,
  input  logic [APB_DW*NUM_RO-1:0] ro_in,
  output logic [APB_DW*NUM_RW-1:0] rw_q,
  output logic [NUM_RW-1:0]        wr_pulse
);

  localparam int         NUM_TOT   = NUM_RW + NUM_RO;
  localparam int         IDX_W     = (NUM_TOT > 1) ? $clog2(NUM_TOT) : 1;
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  apb_state_e state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  // Transfer attributes captured in the setup phase.
  logic [APB_AW-1:0] addr_reg;
  logic              write_reg;
  logic [1:0]        strb_reg;
  logic [APB_DW-1:0] wdata_reg;

  logic              pready_reg, pready_next;
  logic              pslverr_reg, pslverr_next;
  logic [APB_DW-1:0] prdata_reg, prdata_next;

  logic [APB_DW-1:0] rw_reg  [NUM_RW];
  logic [APB_DW-1:0] rw_next [NUM_RW];
  logic [NUM_RW-1:0] wr_pulse_reg, wr_pulse_next;

  logic              setup;
  logic [APB_AW-1:0] dec_addr;
  logic              dec_write;
  logic [1:0]        dec_strb;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_is_rw, dec_is_ro, dec_err;
  logic              xfer_err;
  logic              commit;
  logic [APB_DW-1:0] rd_word;

  assign setup = psel & ~penable;

  // With zero wait states the response is computed in the setup cycle
  // itself, before the latches have loaded, so decode the live bus in IDLE.
  assign dec_addr  = (state_reg == IDLE) ? paddr  : addr_reg;
  assign dec_write = (state_reg == IDLE) ? pwrite : write_reg;
  assign dec_strb  = (state_reg == IDLE) ? pstrb  : strb_reg;

  apb_addr_decode #(
    .BASE_ADDR (BASE_ADDR),
    .NUM_RW    (NUM_RW),
    .NUM_RO    (NUM_RO),
    .IDX_W     (IDX_W)
  ) u_decode (
    .paddr  (dec_addr),
    .pwrite (dec_write),
    .idx    (dec_idx),
    .is_rw  (dec_is_rw),
    .is_ro  (dec_is_ro),
    .err    (dec_err)
  );

  assign xfer_err = dec_err | (dec_write & (dec_strb == 2'b00));

  // The write lands on the edge that ends RESP, unless the master has
  // dropped the transfer during the response cycle.
  assign commit = (state_reg == RESP) & psel & penable & write_reg & ~xfer_err;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        // penable without a setup phase is ignored here.
        if (setup) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
          end else begin
            state_next = WAIT;
            cnt_next   = WAIT_LOAD;
          end
        end
      end
      WAIT: begin
        if (!psel) begin
          state_next = IDLE;
        end else if (cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- read data selection ----------------
  always_comb begin
    rd_word = APB_ERR_DATA;
    for (int k = 0; k < NUM_RW; k++) begin
      if (dec_is_rw && (dec_idx == IDX_W'(k))) rd_word = rw_reg[k];
    end
    for (int k = 0; k < NUM_RO; k++) begin
      if (dec_is_ro && (dec_idx == IDX_W'(NUM_RW + k))) rd_word = ro_in[APB_DW*k +: APB_DW];
    end
  end

  // ---------------- FSM: outputs ----------------
  // Response outputs are computed one cycle ahead from the next state so
  // that they come straight from flops during RESP.
  always_comb begin
    pready_next  = (state_next == RESP);
    pslverr_next = (state_next == RESP) & xfer_err;
    prdata_next  = prdata_reg;
    if ((state_next == RESP) && !dec_write) begin
      prdata_next = xfer_err ? APB_ERR_DATA : rd_word;
    end
  end

  // ---------------- register file write path ----------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_RW; gi++) begin : g_rw
      logic hit;
      assign hit               = commit & dec_is_rw & (dec_idx == IDX_W'(gi));
      assign rw_next[gi]       = hit ? strb_merge(rw_reg[gi], wdata_reg, strb_reg) : rw_reg[gi];
      assign wr_pulse_next[gi] = hit;
      assign rw_q[APB_DW*gi +: APB_DW] = rw_reg[gi];
    end
  endgenerate

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg     <= '0;
      write_reg    <= 1'b0;
      strb_reg     <= 2'b00;
      wdata_reg    <= '0;
      pready_reg   <= 1'b0;
      pslverr_reg  <= 1'b0;
      prdata_reg   <= '0;
      wr_pulse_reg <= '0;
      for (int k = 0; k < NUM_RW; k++) rw_reg[k] <= '0;
    end else begin
      if ((state_reg == IDLE) && setup) begin
        addr_reg  <= paddr;
        write_reg <= pwrite;
        strb_reg  <= pstrb;
        wdata_reg <= pwdata;
      end
      pready_reg   <= pready_next;
      pslverr_reg  <= pslverr_next;
      prdata_reg   <= prdata_next;
      wr_pulse_reg <= wr_pulse_next;
      for (int k = 0; k < NUM_RW; k++) rw_reg[k] <= rw_next[k];
    end
  end

  assign pready   = pready_reg;
  assign pslverr  = pslverr_reg;
  assign prdata   = prdata_reg;
  assign wr_pulse = wr_pulse_reg;

endmodule

// File: tb/tb_apb_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_apb_reg_slave
// Two instances share one bus: u1 with one wait state, u0 with none. A table
// of transfers is applied to u1; hand-written sequences cover zero-wait
// back-to-back, aborts and mid-transfer reset. Expected responses are queued
// when a transfer is driven and checked by a monitor when pready appears.
// ---------------------------------------------------------------------------
module tb_apb_reg_slave;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         psel0, psel1, penable, pwrite;
  logic [1:0]   pstrb;
  logic [19:0]  paddr;
  logic [15:0]  pwdata;
  logic [63:0]  ro_in;
  logic [1:0]   pready_v, pslverr_v;
  logic [15:0]  prdata_v [2];
  logic [127:0] rwq_v    [2];
  logic [7:0]   wrp_v    [2];

  always #5 clk = ~clk;

  apb_reg_slave #(.BASE_ADDR(20'h00000), .NUM_RW(8), .NUM_RO(4), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .pready(pready_v[0]),
    .prdata(prdata_v[0]), .pslverr(pslverr_v[0]), .ro_in(ro_in), .rw_q(rwq_v[0]),
    .wr_pulse(wrp_v[0]));

  apb_reg_slave #(.BASE_ADDR(20'h00000), .NUM_RW(8), .NUM_RO(4), .WAIT_CYCLES(1)) u1 (
    .clk(clk), .reset_n(reset_n), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .pready(pready_v[1]),
    .prdata(prdata_v[1]), .pslverr(pslverr_v[1]), .ro_in(ro_in), .rw_q(rwq_v[1]),
    .wr_pulse(wrp_v[1]));

  typedef struct {
    bit          unit;
    bit          wr;
    bit          commit;
    logic [2:0]  idx;
    bit          err;
    logic [15:0] rdata;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [19:0] addr;
    logic [1:0]  strb;
    logic [15:0] wdata;
    bit          err;
    logic [15:0] rdata;
  } vec_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_on   = 1'b0;
  logic [7:0]  pulse_exp [2] = '{8'h00, 8'h00};
  logic [15:0] model_rw  [2][8];
  int          cyc = 0;
  int          last_setup_cyc, last_resp_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n, input logic [1:0] s);
    logic [15:0] r;
    r = o;
    if (s[0]) r[7:0]  = n[7:0];
    if (s[1]) r[15:8] = n[15:8];
    return r;
  endfunction

  // Scoreboard monitor: wr_pulse every cycle, responses whenever pready is up.
  always @(negedge clk) begin
    exp_t e;
    if (mon_on) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("wr_pulse_u%0d", u), 32'(wrp_v[u]), 32'(pulse_exp[u]));
        pulse_exp[u] = 8'h00;
      end
      for (int u = 0; u < 2; u++) begin
        if (pready_v[u]) begin
          if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_pready_u%0d", u), 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_unit", 32'(u), 32'(e.unit));
            chk($sformatf("pslverr_u%0d", u), 32'(pslverr_v[u]), 32'(e.err));
            if (!e.wr) chk($sformatf("prdata_u%0d", u), 32'(prdata_v[u]), 32'(e.rdata));
            if (e.commit) pulse_exp[u] = 8'd1 << e.idx;
            $display("resp u%0d wr=%0d idx=%0d pslverr=%0d prdata=%h", u, e.wr, e.idx, pslverr_v[u], prdata_v[u]);
          end
        end
      end
    end
  end

  // One APB transfer; drop_in_resp releases psel during RESP (no commit).
  task automatic xfer(input bit u, input bit wr, input logic [19:0] a, input logic [1:0] s,
                      input logic [15:0] d, input bit eerr, input logic [15:0] erd,
                      input bit drop_in_resp);
    exp_t e;
    int   lat;
    bit   seen;
    @(posedge clk); #1;
    psel0 = ~u; psel1 = u; penable = 1'b0;
    pwrite = wr; paddr = a; pstrb = s; pwdata = d;
    last_setup_cyc = cyc;
    e.unit = u; e.wr = wr; e.idx = a[3:1]; e.err = eerr; e.rdata = erd;
    e.commit = wr && !eerr && !drop_in_resp;
    exp_q.push_back(e);
    if (e.commit) model_rw[u][a[3:1]] = merge(model_rw[u][a[3:1]], d, s);
    @(negedge clk);
    chk("pready_in_setup", 32'(pready_v[u]), 32'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (pready_v[u]) seen = 1'b1;
    end
    if (!seen) chk("pready_timeout", 32'd0, 32'd1);
    else chk($sformatf("latency_u%0d", u), 32'(lat), u ? 32'd2 : 32'd1);
    last_resp_cyc = cyc;
    if (drop_in_resp) begin
      // Still inside RESP: release the bus before the committing edge.
      #2; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask

  task automatic check_rwq(input bit u);
    for (int k = 0; k < 8; k++)
      chk($sformatf("rw_q_u%0d_r%0d", u, k), 32'(rwq_v[u][16*k +: 16]), 32'(model_rw[u][k]));
  endtask

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{1'b1, 20'h00004, 2'b11, 16'hA5C3, 1'b0, 16'h0000};
    vecs[1]  = '{1'b0, 20'h00004, 2'b11, 16'h0000, 1'b0, 16'hA5C3};
    vecs[2]  = '{1'b1, 20'h00000, 2'b10, 16'h1234, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 20'h00000, 2'b01, 16'h5678, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 20'h00000, 2'b00, 16'h0000, 1'b0, 16'h1278};
    vecs[5]  = '{1'b0, 20'h00001, 2'b11, 16'h0000, 1'b1, 16'h0000};
    vecs[6]  = '{1'b1, 20'h00010, 2'b11, 16'hFFFF, 1'b1, 16'h0000};
    vecs[7]  = '{1'b0, 20'h00018, 2'b11, 16'h0000, 1'b1, 16'h0000};
    vecs[8]  = '{1'b0, 20'h00010, 2'b00, 16'h0000, 1'b0, 16'hBEEF};
    vecs[9]  = '{1'b1, 20'h0000E, 2'b00, 16'hDDDD, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 20'h0000E, 2'b11, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 20'h0000E, 2'b11, 16'h7E57, 1'b0, 16'h0000};
    vecs[12] = '{1'b0, 20'h0000E, 2'b11, 16'h0000, 1'b0, 16'h7E57};
    vecs[13] = '{1'b0, 20'h00016, 2'b11, 16'h0000, 1'b0, 16'h4444};
    vecs[14] = '{1'b1, 20'h00016, 2'b11, 16'h9999, 1'b1, 16'h0000};

    for (int u = 0; u < 2; u++) for (int k = 0; k < 8; k++) model_rw[u][k] = 16'h0000;
    reset_n = 1'b0; psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    pstrb = 2'b00; paddr = '0; pwdata = '0;
    ro_in = {16'h4444, 16'h3333, 16'h2222, 16'hBEEF};
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_pready",  32'(pready_v[u]),  32'd0);
      chk("reset_pslverr", 32'(pslverr_v[u]), 32'd0);
      chk("reset_prdata",  32'(prdata_v[u]),  32'd0);
      chk("reset_wr_pulse", 32'(wrp_v[u]),    32'd0);
      check_rwq(u[0]);
    end
    mon_on = 1'b1;

    // Table on the one-wait-state instance.
    foreach (vecs[i]) begin
      $display("vec %0d wr=%0d addr=%h strb=%b wdata=%h", i, vecs[i].wr, vecs[i].addr,
               vecs[i].strb, vecs[i].wdata);
      xfer(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].strb, vecs[i].wdata,
           vecs[i].err, vecs[i].rdata, 1'b0);
      idle();
      check_rwq(1'b1);
    end

    // Zero wait states: RO read, then two back-to-back reads in 4 cycles.
    xfer(1'b0, 1'b0, 20'h00010, 2'b00, 16'h0, 1'b0, 16'hBEEF, 1'b0);
    idle();
    xfer(1'b0, 1'b0, 20'h00012, 2'b00, 16'h0, 1'b0, 16'h2222, 1'b0);
    begin
      int s1;
      s1 = last_setup_cyc;
      xfer(1'b0, 1'b0, 20'h00014, 2'b00, 16'h0, 1'b0, 16'h3333, 1'b0);
      chk("b2b_cycles", 32'(last_resp_cyc - s1 + 1), 32'd4);
      $display("b2b reads: first setup cyc %0d, second resp cyc %0d", s1, last_resp_cyc);
    end
    // Back-to-back write then read of the same register.
    xfer(1'b0, 1'b1, 20'h00002, 2'b11, 16'hCAFE, 1'b0, 16'h0, 1'b0);
    xfer(1'b0, 1'b0, 20'h00002, 2'b11, 16'h0,    1'b0, 16'hCAFE, 1'b0);
    idle();
    check_rwq(1'b0);

    // Abort during WAIT: no response, no commit.
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00006; pstrb = 2'b11; pwdata = 16'h1111;
    @(posedge clk); #1;
    psel1 = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_wait_pready", 32'(pready_v[1]), 32'd0);
    end
    check_rwq(1'b1);
    $display("abort in WAIT done");

    // Abort during RESP: response seen, but the write must not land.
    xfer(1'b1, 1'b1, 20'h00008, 2'b11, 16'h2222, 1'b0, 16'h0, 1'b1);
    @(negedge clk);
    chk("abort_resp_pready_next", 32'(pready_v[1]), 32'd0);
    check_rwq(1'b1);

    // Reset in the middle of WAIT.
    @(posedge clk); #1;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 20'h00004; pstrb = 2'b11; pwdata = 16'h3333;
    @(posedge clk); #1;
    penable = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("midreset_pready",   32'(pready_v[1]),  32'd0);
    chk("midreset_pslverr",  32'(pslverr_v[1]), 32'd0);
    chk("midreset_prdata",   32'(prdata_v[1]),  32'd0);
    chk("midreset_wr_pulse", 32'(wrp_v[1]),     32'd0);
    for (int u = 0; u < 2; u++) for (int k = 0; k < 8; k++) model_rw[u][k] = 16'h0000;
    check_rwq(1'b1);
    psel1 = 1'b0; penable = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    $display("mid-WAIT reset done");
    xfer(1'b1, 1'b0, 20'h00004, 2'b11, 16'h0, 1'b0, 16'h0000, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/apb_reg_slave.md
# apb_reg_slave

APB completer that terminates one select line of the SPI slave's APB master port (`psel_s[0]` or `psel_s[1]`) and exposes a 16-bit register file to the crypto core. It decodes halfword addresses, inserts a programmable number of wait states, and performs byte-lane writes via `pstrb`. It flags decode and access errors on `pslverr`, which the master converts into its error response.

## Interface
- `BASE_ADDR`, 20'h00000: first byte address of the register window.
- `NUM_RW`, 8: number of read/write registers, indices 0..NUM_RW-1.
- `NUM_RO`, 4: number of read-only registers, indices NUM_RW..NUM_RW+NUM_RO-1.
- `WAIT_CYCLES`, 1: wait states inserted before `pready` (0..15).

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: reset. Asynchronous, active-low.
- `psel` in 1: APB select, one bit of the master's `psel_s`.
- `penable` in 1: APB enable.
- `pwrite` in 1: 1 = write, 0 = read.
- `pstrb` in 2: byte-lane strobes. Bit 1 = [15:8], bit 0 = [7:0].
- `paddr` in 20: byte address.
- `pwdata` in 16: write data.
- `pready` out 1: transfer complete, registered.
- `prdata` out 16: read data, registered.
- `pslverr` out 1: error response, valid only while `pready`=1, registered.
- `ro_in` in 16*NUM_RO: hardware status values. Read-only register k is `ro_in[16k+15:16k]`.
- `rw_q` out 16*NUM_RW: register file contents, flattened.
- `wr_pulse` out NUM_RW: one-cycle strobe per RW register on a committed write.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE.** A setup phase is `psel`=1 and `penable`=0. On a setup phase, latch `paddr`, `pwrite`, `pstrb` and `pwdata`, then decode.
  - If WAIT_CYCLES=0, go to RESP.
  - Otherwise load `cnt`=WAIT_CYCLES-1 and go to WAIT.
- **WAIT.** Decrement `cnt` each cycle. Go to RESP when `cnt`=0.
- **RESP.** `pready`=1 for exactly this one cycle, with `prdata` and `pslverr` valid. Then return to IDLE.
- **Decode.**
  - off = `paddr` − `BASE_ADDR`, 20-bit unsigned. idx = off >> 1.
  - Error (`pslverr`=1) if any of the following holds:
    - `paddr` < `BASE_ADDR`;
    - `paddr[0]`=1;
    - idx ≥ NUM_RW+NUM_RO;
    - a write to a read-only index;
    - a write with `pstrb`=2'b00.
- **Read.**
  - `prdata` = `rw_q` word or `ro_in` word for idx.
  - `ro_in` is sampled in the cycle before RESP.
  - On error, `prdata`=16'h0000.
  - `pstrb` is ignored on reads.
- **Write.**
  - Commits only on the clock edge that ends RESP, and only when `psel`&`penable`=1 and there is no error.
  - Byte lanes are updated per `pstrb`.
  - `wr_pulse[idx]`=1 during the cycle after commit, the same cycle the new `rw_q` value is visible.
  - An errored write changes nothing and produces no `wr_pulse`.
- **Abort.** If `psel` falls in WAIT or RESP, return to IDLE immediately. No write commits, no `wr_pulse`, and `pready` is forced to 0 on the next cycle.
- **Protocol violations.**
  - `penable`=1 without a preceding setup phase is ignored while in IDLE.
  - Address and data changes during WAIT are ignored; the latched values are used.
- **Back-to-back transfers.** A new setup phase in the cycle after RESP is accepted. Throughput is one transfer per 2+WAIT_CYCLES cycles.
- **Reset.** Takes effect at any time, including mid-transfer: state=IDLE, `pready`=0, `prdata`=16'h0000, `pslverr`=0, all `rw_q`=0, `wr_pulse`=0, `cnt`=0.

## Timing
- **Latency.** Setup at cycle T gives `pready`=1 at cycle T+1+WAIT_CYCLES, in the master's ACCESS phase.
- **Response outputs.** `pready` and `pslverr` are high for one cycle only. `prdata` holds its last value after RESP until the next read response.
- **Write visibility.**
  - Write data is visible on `rw_q` at T+2+WAIT_CYCLES.
  - A read of the same register issued in the following transfer returns the new value.
- **Combinational paths.** There is no combinational path from any input to `pready`, `prdata` or `pslverr`.

## Structure
- Shared package `apb_pkg` holds:
  - state encodings IDLE/WAIT/RESP;
  - `APB_AW`=20 and `APB_DW`=16;
  - the error read value `APB_ERR_DATA`=16'h0000;
  - the `DEAD` marker 16'h4552 used by the master.
- One sub-module: `apb_addr_decode`. It is combinational: `paddr` and `pwrite` in; idx, is_rw, is_ro and err out. This module contains the FSM, the counter and the register file.

## Test plan
- **RW write then read.** WAIT_CYCLES=1, BASE=0. Write 16'hA5C3 to 0x00004 with `pstrb`=11 → `pready` at T+2, `pslverr`=0, `wr_pulse[2]`=1 once. Read 0x00004 → `prdata`=16'hA5C3.
- **Byte lanes.** Write 16'h1234 to register 0 with `pstrb`=10, then 16'h5678 with `pstrb`=01 → register 0 reads 16'h1278.
- **Errors.**
  - Read 0x00001 (odd) → `pslverr`=1, `prdata`=0.
  - Write 0x00010 (idx 8, RO) → `pslverr`=1; `rw_q` unchanged, no `wr_pulse`.
  - Read 0x00018 (idx 12, out of range) → `pslverr`=1.
- **Read-only registers and zero-wait back-to-back.** `ro_in[15:0]`=16'hBEEF, WAIT_CYCLES=0. Read 0x00010 → `pready` at T+1, `prdata`=16'hBEEF. Two back-to-back reads complete in 4 cycles.
- **Abort and reset.**
  - Write setup, then drop `psel` during WAIT → no commit, `pready` stays 0.
  - Assert `reset_n` low mid-WAIT → all outputs return to their reset values immediately.
